// File: rtl/my_nios_timer_arb_pkg.sv
// Register map, command words and FSM encoding shared by the timer arbiter files.
package my_nios_timer_arb_pkg;

  localparam logic [2:0] TMR_ADDR_STATUS  = 3'd0;
  localparam logic [2:0] TMR_ADDR_CONTROL = 3'd1;
  localparam logic [2:0] TMR_ADDR_PERIODL = 3'd2;
  localparam logic [2:0] TMR_ADDR_PERIODH = 3'd3;

  localparam logic [15:0] CTRL_ITO   = 16'h0001;
  localparam logic [15:0] CTRL_CONT  = 16'h0002;
  localparam logic [15:0] CTRL_START = 16'h0004;
  localparam logic [15:0] CTRL_STOP  = 16'h0008;

  // One-shot start: CONT is deliberately left clear so the timer stops after one timeout.
  localparam logic [15:0] CMD_ONESHOT  = (CTRL_START | CTRL_ITO) & ~CTRL_CONT;
  localparam logic [15:0] CMD_STOP     = CTRL_STOP;
  localparam logic [15:0] STATUS_CLEAR = 16'h0000;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CLR0,
    S_WPL,
    S_WPH,
    S_WCTL,
    S_WAIT,
    S_STOP,
    S_CLR1,
    S_FIN
  } state_e;

endpackage

// File: rtl/my_nios_rr_arbiter.sv
// Round-robin winner selection; the pointer holds the last granted index.
module my_nios_rr_arbiter
  import my_nios_timer_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               enable_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [2:0]         ptr_o
);

  logic [2:0] ptr_q, ptr_d;
  logic [2:0] win_idx;
  logic       found;
  logic [3:0] cand;

  // Search starts one past the last winner and wraps modulo NUM_REQ.
  always_comb begin
    found   = 1'b0;
    win_idx = ptr_q;
    cand    = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = {1'b0, ptr_q} + 4'(i);
      if (cand >= 4'(NUM_REQ)) begin
        cand = cand - 4'(NUM_REQ);
      end
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!found && req_i[j] && (cand == 4'(j))) begin
          found   = 1'b1;
          win_idx = 3'(j);
        end
      end
    end
  end

  always_comb begin
    grant_o = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      grant_o[j] = enable_i && found && (win_idx == 3'(j));
    end
    ptr_d = (enable_i && found) ? win_idx : ptr_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= 3'(NUM_REQ - 1);
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/my_nios_timer_arbiter.sv
// Shares one Avalon interval timer between NUM_REQ one-shot delay requesters.
// Optional watchdog abort is enabled by defining TIMER_ARB_WATCHDOG_EN.
module my_nios_timer_arbiter
  import my_nios_timer_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int WDOG_MARGIN = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [32*NUM_REQ-1:0]  req_period,
  input  logic [NUM_REQ-1:0]     req_cancel,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [NUM_REQ-1:0]     req_done,
  output logic [NUM_REQ-1:0]     req_aborted,
  output logic                   busy,
  output logic [2:0]             grant_id,
  output logic                   wdog_err,
  output logic [2:0]             tmr_address,
  output logic                   tmr_chipselect,
  output logic                   tmr_write_n,
  output logic [15:0]            tmr_writedata,
  input  logic                   tmr_irq
);

  state_e             state_q, state_d;
  logic [31:0]        period_q, period_d;
  logic               abort_q, abort_d;
  logic [NUM_REQ-1:0] arb_grant;
  logic [NUM_REQ-1:0] grant_onehot;
  logic [31:0]        sel_period;
  logic               cancel_hit;
  logic               wdog_hit;

  my_nios_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .clk      (clk),
    .reset    (reset),
    .req_i    (req_valid),
    .enable_i (state_q == S_IDLE),
    .grant_o  (arb_grant),
    .ptr_o    (grant_id)
  );

  assign grant_onehot = NUM_REQ'(1) << grant_id;
  assign cancel_hit   = |(req_cancel & grant_onehot);

  always_comb begin
    sel_period = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (arb_grant[j]) begin
        sel_period = req_period[32*j +: 32];
      end
    end
  end

`ifdef TIMER_ARB_WATCHDOG_EN
  logic [32:0] wdog_cnt_q, wdog_cnt_d;
  logic        wdog_err_q;

  // Counter is held at zero outside WAIT, so it restarts on every WAIT entry.
  always_comb begin
    wdog_cnt_d = '0;
    if (state_q == S_WAIT) begin
      wdog_cnt_d = wdog_cnt_q + 33'd1;
    end
  end

  assign wdog_hit = (state_q == S_WAIT) &&
                    (wdog_cnt_d >= ({1'b0, period_q} + 33'(WDOG_MARGIN)));

  always_ff @(posedge clk) begin
    if (reset) begin
      wdog_cnt_q <= '0;
      wdog_err_q <= 1'b0;
    end else begin
      wdog_cnt_q <= wdog_cnt_d;
      wdog_err_q <= wdog_hit && !tmr_irq;
    end
  end

  assign wdog_err = wdog_err_q;
`else
  assign wdog_hit = 1'b0;
  assign wdog_err = 1'b0;
`endif

  // An irq in WAIT always wins over cancel or watchdog expiry.
  always_comb begin
    state_d  = state_q;
    period_d = period_q;
    abort_d  = abort_q;
    unique case (state_q)
      S_IDLE: begin
        if (|arb_grant) begin
          state_d  = S_CLR0;
          period_d = sel_period;
          abort_d  = 1'b0;
        end
      end
      S_CLR0: state_d = S_WPL;
      S_WPL:  state_d = S_WPH;
      S_WPH:  state_d = S_WCTL;
      S_WCTL: state_d = S_WAIT;
      S_WAIT: begin
        if (tmr_irq) begin
          state_d = S_CLR1;
        end else if (cancel_hit || wdog_hit) begin
          state_d = S_STOP;
          abort_d = 1'b1;
        end
      end
      S_STOP: state_d = S_CLR1;
      S_CLR1: state_d = S_FIN;
      S_FIN:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      period_q <= '0;
      abort_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      period_q <= period_d;
      abort_q  <= abort_d;
    end
  end

  always_comb begin
    tmr_chipselect = 1'b0;
    tmr_write_n    = 1'b1;
    tmr_address    = TMR_ADDR_STATUS;
    tmr_writedata  = '0;
    case (state_q)
      S_CLR0, S_CLR1: begin
        tmr_chipselect = 1'b1;
        tmr_write_n    = 1'b0;
        tmr_address    = TMR_ADDR_STATUS;
        tmr_writedata  = STATUS_CLEAR;
      end
      S_WPL: begin
        tmr_chipselect = 1'b1;
        tmr_write_n    = 1'b0;
        tmr_address    = TMR_ADDR_PERIODL;
        tmr_writedata  = period_q[15:0];
      end
      S_WPH: begin
        tmr_chipselect = 1'b1;
        tmr_write_n    = 1'b0;
        tmr_address    = TMR_ADDR_PERIODH;
        tmr_writedata  = period_q[31:16];
      end
      S_WCTL: begin
        tmr_chipselect = 1'b1;
        tmr_write_n    = 1'b0;
        tmr_address    = TMR_ADDR_CONTROL;
        tmr_writedata  = CMD_ONESHOT;
      end
      S_STOP: begin
        tmr_chipselect = 1'b1;
        tmr_write_n    = 1'b0;
        tmr_address    = TMR_ADDR_CONTROL;
        tmr_writedata  = CMD_STOP;
      end
      default: begin
        tmr_chipselect = 1'b0;
      end
    endcase
  end

  assign busy        = (state_q != S_IDLE);
  assign req_ready   = arb_grant;
  assign req_done    = (state_q == S_FIN && !abort_q) ? grant_onehot : '0;
  assign req_aborted = (state_q == S_FIN &&  abort_q) ? grant_onehot : '0;

endmodule

// File: tb/tb_my_nios_timer_arbiter.sv
// Scoreboard bench for my_nios_timer_arbiter; the watchdog scenario runs when TIMER_ARB_WATCHDOG_EN is defined.
`timescale 1ns/1ps
module tb_my_nios_timer_arbiter;

  localparam int NUM_REQ     = 4;
  localparam int WDOG_MARGIN = 16;

  localparam logic [2:0] EV_READY = 3'd0;
  localparam logic [2:0] EV_WRITE = 3'd1;
  localparam logic [2:0] EV_DONE  = 3'd2;
  localparam logic [2:0] EV_ABORT = 3'd3;
  localparam logic [2:0] EV_WDOG  = 3'd4;

  typedef struct packed {
    logic [2:0]  kind;
    logic [15:0] a;
    logic [15:0] b;
  } event_t;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic [NUM_REQ-1:0]    req_valid = '0;
  logic [32*NUM_REQ-1:0] req_period = '0;
  logic [NUM_REQ-1:0]    req_cancel = '0;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ-1:0]    req_done;
  logic [NUM_REQ-1:0]    req_aborted;
  logic                  busy;
  logic [2:0]            grant_id;
  logic                  wdog_err;
  logic [2:0]            tmr_address;
  logic                  tmr_chipselect;
  logic                  tmr_write_n;
  logic [15:0]           tmr_writedata;
  logic                  tmr_irq = 1'b0;

  event_t expQ[$];
  int numCompared = 0;
  int numMismatched = 0;

  my_nios_timer_arbiter #(
    .NUM_REQ     (NUM_REQ),
    .WDOG_MARGIN (WDOG_MARGIN)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_period     (req_period),
    .req_cancel     (req_cancel),
    .req_ready      (req_ready),
    .req_done       (req_done),
    .req_aborted    (req_aborted),
    .busy           (busy),
    .grant_id       (grant_id),
    .wdog_err       (wdog_err),
    .tmr_address    (tmr_address),
    .tmr_chipselect (tmr_chipselect),
    .tmr_write_n    (tmr_write_n),
    .tmr_writedata  (tmr_writedata),
    .tmr_irq        (tmr_irq)
  );

  always #5 clk = ~clk;

  function automatic event_t mkEvent(input logic [2:0] kind, input logic [15:0] a, input logic [15:0] b);
    event_t e;
    e.kind = kind;
    e.a    = a;
    e.b    = b;
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    numCompared++;
    if (actual !== expected) begin
      numMismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic scoreEvent(input event_t got);
    event_t want;
    numCompared++;
    if (expQ.size() == 0) begin
      numMismatched++;
      $display("[TB] FAIL unexpected event: got kind=%0d a=0x%0h b=0x%0h with nothing expected",
               got.kind, got.a, got.b);
    end else begin
      want = expQ.pop_front();
      if (got !== want) begin
        numMismatched++;
        $display("[TB] FAIL scoreboard: got kind=%0d a=0x%0h b=0x%0h expected kind=%0d a=0x%0h b=0x%0h",
                 got.kind, got.a, got.b, want.kind, want.a, want.b);
      end
    end
  endtask

  // Monitor: every visible DUT output event is matched against the expectation queue.
  always @(negedge clk) begin
    if (!reset) begin
      if (req_ready != '0) scoreEvent(mkEvent(EV_READY, 16'(req_ready), 16'h0000));
      if (wdog_err) scoreEvent(mkEvent(EV_WDOG, 16'h0000, 16'h0000));
      if (tmr_chipselect && !tmr_write_n) scoreEvent(mkEvent(EV_WRITE, 16'(tmr_address), tmr_writedata));
      if (req_done != '0) scoreEvent(mkEvent(EV_DONE, 16'(req_done), 16'h0000));
      if (req_aborted != '0) scoreEvent(mkEvent(EV_ABORT, 16'(req_aborted), 16'h0000));
    end
  end

  task automatic resetDut();
    checkOutput("scoreboard drained before reset", 32'(expQ.size()), 32'd0);
    expQ.delete();
    reset      = 1'b1;
    req_valid  = '0;
    req_cancel = '0;
    tmr_irq    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic waitAccept(input string name);
    int cycles = 0;
    @(negedge clk);
    while (req_ready == '0 && cycles < 100) begin
      @(negedge clk);
      cycles++;
    end
    checkOutput(name, 32'(req_ready != '0), 32'd1);
    @(posedge clk);
    #1;
  endtask

  // Issues a request from k and walks it to the first WAIT cycle, checking write latency.
  task automatic applyStimulus(input int k, input logic [31:0] period, input bit dropValid);
    expQ.push_back(mkEvent(EV_READY, 16'(1 << k), 16'h0000));
    expQ.push_back(mkEvent(EV_WRITE, 16'd0, 16'h0000));
    expQ.push_back(mkEvent(EV_WRITE, 16'd2, period[15:0]));
    expQ.push_back(mkEvent(EV_WRITE, 16'd3, period[31:16]));
    expQ.push_back(mkEvent(EV_WRITE, 16'd1, 16'h0005));
    req_period[32*k +: 32] = period;
    req_valid[k] = 1'b1;
    waitAccept("accept");
    if (dropValid) req_valid[k] = 1'b0;
    checkOutput("grant_id after accept", 32'(grant_id), 32'(k));
    checkOutput("CLR0 right after accept", 32'({tmr_chipselect, tmr_write_n, tmr_address}), 32'b1_0_000);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("WCTL address/data at N+4", 32'({tmr_address, tmr_writedata}), 32'({3'd1, 16'h0005}));
    @(posedge clk);
    #1;
    checkOutput("WAIT at N+5 quiet and busy", 32'({busy, tmr_chipselect}), 32'b10);
  endtask

  task automatic fireIrq(input int k, input bit withCancel);
    expQ.push_back(mkEvent(EV_WRITE, 16'd0, 16'h0000));
    expQ.push_back(mkEvent(EV_DONE, 16'(1 << k), 16'h0000));
    tmr_irq = 1'b1;
    if (withCancel) req_cancel[k] = 1'b1;
    @(posedge clk);
    #1;
    tmr_irq    = 1'b0;
    req_cancel = '0;
    checkOutput("CLR1 after irq", 32'({tmr_chipselect, tmr_address, tmr_writedata}), 32'({1'b1, 3'd0, 16'h0000}));
    @(posedge clk);
    #1;
    checkOutput("done pulse", 32'(req_done), 32'(1 << k));
    checkOutput("no abort with done", 32'(req_aborted), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("idle after done", 32'(busy), 32'd0);
  endtask

  task automatic cancelDelay(input int k);
    expQ.push_back(mkEvent(EV_WRITE, 16'd1, 16'h0008));
    expQ.push_back(mkEvent(EV_WRITE, 16'd0, 16'h0000));
    expQ.push_back(mkEvent(EV_ABORT, 16'(1 << k), 16'h0000));
    req_cancel[k] = 1'b1;
    @(posedge clk);
    #1;
    req_cancel = '0;
    checkOutput("STOP write", 32'({tmr_address, tmr_writedata}), 32'({3'd1, 16'h0008}));
    repeat (2) @(posedge clk);
    #1;
    checkOutput("aborted pulse", 32'(req_aborted), 32'(1 << k));
    checkOutput("no done on abort", 32'(req_done), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("idle after abort", 32'(busy), 32'd0);
  endtask

  initial begin
    #2000000;
    numMismatched++;
    $display("[TB] FAIL global timeout: simulation did not complete, got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
    $finish;
  end

  initial begin
    $display("[TB] start");
    resetDut();
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset grant_id", 32'(grant_id), 32'd3);
    checkOutput("reset pulses", 32'({req_ready, req_done, req_aborted, wdog_err}), 32'd0);
    checkOutput("reset master idle", 32'({tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata}),
                32'({1'b0, 1'b1, 3'd0, 16'h0000}));

    $display("[TB] single request k=0 period 100");
    applyStimulus(0, 32'd100, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    checkOutput("still waiting without irq", 32'(busy), 32'd1);
    fireIrq(0, 1'b0);

    $display("[TB] all requesters held, round robin");
    resetDut();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(i % 4, 32'h0001_0100 + 32'(i), 1'b0);
      req_valid = 4'hF;
      if (i == 4) req_valid = '0;
      fireIrq(i % 4, 1'b0);
    end

    $display("[TB] cancel k=2 during WAIT");
    resetDut();
    applyStimulus(2, 32'h0001_2345, 1'b1);
    req_cancel[0] = 1'b1;
    req_valid[0]  = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    req_cancel[0] = 1'b0;
    req_valid[0]  = 1'b0;
    checkOutput("foreign cancel ignored", 32'({busy, tmr_chipselect}), 32'b10);
    cancelDelay(2);

    $display("[TB] irq and cancel in the same cycle");
    resetDut();
    applyStimulus(1, 32'h0000_0200, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    fireIrq(1, 1'b1);

    $display("[TB] reset during WAIT");
    resetDut();
    applyStimulus(0, 32'd50, 1'b1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("busy after mid-op reset", 32'(busy), 32'd0);
    checkOutput("grant_id after mid-op reset", 32'(grant_id), 32'd3);
    checkOutput("master idle after mid-op reset",
                32'({tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata}), 32'({1'b0, 1'b1, 3'd0, 16'h0000}));
    checkOutput("no pulses after mid-op reset", 32'({req_done, req_aborted, wdog_err}), 32'd0);
    applyStimulus(3, 32'hABCD_0042, 1'b1);
    fireIrq(3, 1'b0);

`ifdef TIMER_ARB_WATCHDOG_EN
    $display("[TB] watchdog period 20");
    resetDut();
    applyStimulus(0, 32'd20, 1'b1);
    expQ.push_back(mkEvent(EV_WDOG, 16'h0000, 16'h0000));
    expQ.push_back(mkEvent(EV_WRITE, 16'd1, 16'h0008));
    expQ.push_back(mkEvent(EV_WRITE, 16'd0, 16'h0000));
    expQ.push_back(mkEvent(EV_ABORT, 16'h0001, 16'h0000));
    repeat (35) @(posedge clk);
    #1;
    checkOutput("wdog quiet before limit", 32'({busy, wdog_err}), 32'b10);
    @(posedge clk);
    #1;
    checkOutput("wdog pulse 36 cycles after WAIT", 32'(wdog_err), 32'd1);
    checkOutput("wdog STOP write", 32'({tmr_address, tmr_writedata}), 32'({3'd1, 16'h0008}));
    @(posedge clk);
    #1;
    checkOutput("wdog pulse one cycle", 32'(wdog_err), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("wdog aborted pulse", 32'(req_aborted), 32'd1);
    @(posedge clk);
    #1;
    checkOutput("idle after wdog", 32'(busy), 32'd0);
`endif

    repeat (3) @(posedge clk);
    #1;
    checkOutput("scoreboard drained at end", 32'(expQ.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
    $finish;
  end

endmodule

// File: doc/my_nios_timer_arbiter.md
# my_nios_timer_arbiter

- Shares one interval-timer core between `NUM_REQ` hardware requesters, each asking for a one-shot delay.
- It sits between the requesters and the timer's Avalon-MM slave, driving that slave as a master.
- It arbitrates round-robin, programs period and control, waits for the timer IRQ, then clears status and reports completion.
- It also supports per-requester cancel and an optional watchdog.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, 2..8.
- `WDOG_MARGIN`, 16: extra cycles allowed beyond the programmed period before the watchdog fires.

Ports:
- `clk`, in, 1: single clock.
- `reset`, in, 1: synchronous, active-high reset.
- `req_valid`, in, NUM_REQ: request per requester; held until accepted.
- `req_period`, in, 32*NUM_REQ: packed per-requester period; slice k is [32k+31:32k].
- `req_cancel`, in, NUM_REQ: level; aborts the granted requester's active delay.
- `req_ready`, out, NUM_REQ: one-hot acceptance pulse.
- `req_done`, out, NUM_REQ: one-hot pulse on timeout completion.
- `req_aborted`, out, NUM_REQ: one-hot pulse on cancel or watchdog completion.
- `busy`, out, 1: FSM not in IDLE.
- `grant_id`, out, 3: index of the current or last granted requester.
- `wdog_err`, out, 1: one-cycle pulse on watchdog expiry.
- `tmr_address`, out, 3: timer register address.
- `tmr_chipselect`, out, 1: timer chipselect.
- `tmr_write_n`, out, 1: timer write strobe, active low.
- `tmr_writedata`, out, 16: timer write data.
- `tmr_irq`, in, 1: timer interrupt.

## Operation
- Timer map: 0 STATUS, 1 CONTROL, 2 PERIODL, 3 PERIODH.
- CONTROL bits: 0 ITO, 1 CONT, 2 START, 3 STOP.
- Any write to STATUS clears the timeout flag.
- FSM states: IDLE -> CLR0 -> WPL -> WPH -> WCTL -> WAIT -> CLR1 -> FIN -> IDLE.
- Abort path: WAIT -> STOP -> CLR1 -> FIN.
- Each state from CLR0 through CLR1, plus STOP, issues exactly one single-cycle write (`tmr_chipselect`=1, `tmr_write_n`=0). The timer slave takes zero wait states on writes.
- Write sequence:
  - CLR0 writes 0x0000 to STATUS, discarding any stale flag.
  - WPL writes period[15:0].
  - WPH writes period[31:16].
  - WCTL writes 0x0005 to CONTROL (START|ITO, one-shot).
  - STOP writes 0x0008 to CONTROL.
  - CLR1 writes 0x0000 to STATUS.
- Period is written verbatim; the timeout delay follows the timer core's own semantics.
- IDLE arbitration:
  - Round-robin; search starts at `grant_id`+1 mod NUM_REQ.
  - The winner k gets `req_ready[k]`=1 in the same cycle (combinational from `req_valid` in IDLE).
  - Period slice k and `grant_id` register at that edge.
- WAIT exits:
  - `tmr_irq`=1 -> CLR1, FIN pulses `req_done[grant_id]`.
  - `req_cancel[grant_id]`=1 -> STOP, FIN pulses `req_aborted[grant_id]`.
  - If both are asserted in the same cycle, irq wins and `req_done` pulses.
- Cancel asserted by a non-granted requester, or outside WAIT, has no effect. Such a requester withdraws by dropping `req_valid`.
- All outputs are decoded from registered state. Idle master outputs: `tmr_chipselect`=0, `tmr_write_n`=1, `tmr_address`=0, `tmr_writedata`=0.

## Timing
- Reset values:
  - FSM = IDLE, `grant_id` = NUM_REQ-1, so requester 0 is first.
  - `req_ready`, `req_done`, `req_aborted`, `busy`, `wdog_err` = 0.
  - Master outputs at idle values.
- Latency: accept at cycle N; writes occur at N+1..N+4 (addresses 0, 2, 3, 1); WAIT starts at N+5.
- If irq is first sampled high at M: CLR1 at M+1, done pulse at M+2, IDLE at M+3.
- Next grant is possible at M+3; minimum turnaround is 8 cycles plus timer time.
- Reset mid-operation: the FSM returns to IDLE next edge and no done/abort pulses.
  - The timer core itself is not reset.
  - CLR0 plus a full reprogram on the next grant makes that safe.
- `req_valid` dropped before `req_ready`: no grant and no side effects.

## Configuration
- `TIMER_ARB_WATCHDOG_EN` defined:
  - A 33-bit counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches period+WDOG_MARGIN, the FSM takes the abort path (STOP -> CLR1 -> FIN).
  - `wdog_err` pulses at entry to STOP, and `req_aborted` pulses in FIN.
  - A cancel arriving in the same cycle also takes the abort path, with `wdog_err` still pulsed.
- Undefined: WAIT waits indefinitely, `wdog_err` is tied 0, and no counter is generated.

## Structure
- Package `my_nios_timer_arb_pkg` holds:
  - timer register address constants;
  - CONTROL bit masks and the 0x0005/0x0008 command words;
  - the FSM state enum.
- Sub-module `my_nios_rr_arbiter` holds the round-robin pointer and one-hot winner logic, parameterized by NUM_REQ.
- The top level holds the FSM, the period capture register and the watchdog.

## Test plan
- Single request, k=0, period 100: writes (0,0x0000), (2,100), (3,0), (1,0x0005) on consecutive cycles; irq after delay -> write (0,0) then `req_done[0]` pulse.
- All four `req_valid` held: grants 0,1,2,3,0 in order, one `req_ready` pulse each, no overlap.
- Cancel k=2 during WAIT: write (1,0x0008), then (0,0), then `req_aborted[2]` pulse, no `req_done`.
- irq and `req_cancel[grant_id]` in the same WAIT cycle: `req_done` pulses, no STOP write.
- Reset asserted in WAIT: outputs at reset values next cycle; the following request reissues the full 4-write sequence.
- Watchdog (macro on), period 20, irq held low: `wdog_err` fires 36 cycles after WAIT entry, followed by STOP, CLR1 and `req_aborted`.
